pong_game_engine: RTL and testbench

Per-frame game-state engine for the Pong display path. It advances both paddles from player buttons and the ball (including wall and paddle bounces), scores points and sequences serve, pause and game-over. Its coordinate outputs feed the VGA pixel generator directly: 10-bit paddle top-left coordinates and the ball centre. The engine updates only on the once-per-frame strobe.

---
 rtl/pong_game_engine.sv | 195 +++++++++++++++++++
 tb/tb_pong_game_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_engine.sv
// Frame-rate Pong state engine: paddles, ball motion with wall/paddle bounces, scoring, serve/pause/game-over sequencing.
// All registers advance only on the clk edge where frame_pulse is high.
module pong_game_engine #(
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60,
  parameter int P1_X         = 16,
  parameter int P2_X         = 614
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_pulse,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  input  logic       serve,
  output logic [9:0] x1,
  output logic [9:0] y1,
  output logic [9:0] x2,
  output logic [9:0] y2,
  output logic [9:0] xb,
  output logic [9:0] yb,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over
);

  localparam int CW = $clog2(PAUSE_FRAMES + 1);

  localparam logic [9:0] PAD_Y_MIN  = 10'd8;
  localparam logic [9:0] PAD_Y_MAX  = 10'd392;
  localparam logic [9:0] PAD_Y_RST  = 10'd200;
  localparam logic [9:0] PAD_STEP   = 10'(PADDLE_SPEED);
  localparam logic [9:0] BALL_X_CTR = 10'd320;
  localparam logic [9:0] BALL_Y_CTR = 10'd240;
  localparam logic [9:0] XB_HIT_L   = 10'(P1_X + 14);
  localparam logic [9:0] XB_HIT_R   = 10'(P2_X - 4);
  localparam logic [9:0] XB_MISS_L  = 10'd4;
  localparam logic [9:0] XB_MISS_R  = 10'd635;
  localparam logic [3:0] SCORE_WIN  = 4'(WIN_SCORE);

  localparam logic signed [10:0] B_STEP = 11'(BALL_SPEED);
  localparam logic signed [10:0] Y_TOP  = 11'sd12;
  localparam logic signed [10:0] Y_BOT  = 11'sd468;
  localparam logic signed [10:0] X_LO   = 11'sd4;
  localparam logic signed [10:0] X_HI   = 11'sd635;
  localparam logic signed [10:0] PX1    = 11'(P1_X);
  localparam logic signed [10:0] PX2    = 11'(P2_X);

  // states: SERVE ball parked at centre | PLAY ball moving | POINT post-miss pause | OVER wait for serve
  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t          state;
  logic            dx, dy;
  logic            serve_q;
  logic [CW-1:0]   pause_cnt;

  logic            serve_edge;
  logic [9:0]      y1_next, y2_next;
  logic signed [10:0] xb_s, yb_s, nx, ny, yb_ns;
  logic [9:0]      xb_n, yb_n;
  logic            dx_n, dy_n;
  logic            hit_l, hit_r, miss_l, miss_r;

  function automatic logic [9:0] paddle_next(logic [9:0] y, logic up, logic dn);
    if (up && !dn)
      return (y < PAD_Y_MIN + PAD_STEP) ? PAD_Y_MIN : y - PAD_STEP;
    else if (dn && !up)
      return (y > PAD_Y_MAX - PAD_STEP) ? PAD_Y_MAX : y + PAD_STEP;
    else
      return y;
  endfunction

  function automatic logic v_overlap(logic signed [10:0] ball_y, logic [9:0] pad_y);
    logic signed [10:0] p;
    p = {1'b0, pad_y};
    return (ball_y + 11'sd3 >= p) && (ball_y - 11'sd4 <= p + 11'sd79);
  endfunction

  assign x1         = 10'(P1_X);
  assign x2         = 10'(P2_X);
  assign serve_edge = serve && !serve_q;
  assign y1_next    = paddle_next(y1, p1_up, p1_dn);
  assign y2_next    = paddle_next(y2, p2_up, p2_dn);
  assign xb_s       = {1'b0, xb};
  assign yb_s       = {1'b0, yb};

  always_comb begin
    nx = dx ? xb_s + B_STEP : xb_s - B_STEP;
    ny = dy ? yb_s + B_STEP : yb_s - B_STEP;

    yb_n = ny[9:0];
    dy_n = dy;
    if (ny < Y_TOP) begin
      yb_n = 10'(Y_TOP);
      dy_n = 1'b1;
    end else if (ny > Y_BOT) begin
      yb_n = 10'(Y_BOT);
      dy_n = 1'b0;
    end
    yb_ns = {1'b0, yb_n};

    // paddle overlap is judged against this frame's ball y but last frame's paddle y
    hit_l  = !dx && (nx - 11'sd4 >= PX1) && (nx - 11'sd4 <= PX1 + 11'sd9) && v_overlap(yb_ns, y1);
    hit_r  = dx && (nx + 11'sd3 >= PX2) && (nx + 11'sd3 <= PX2 + 11'sd9) && v_overlap(yb_ns, y2);
    miss_l = !hit_l && !hit_r && (nx < X_LO);
    miss_r = !hit_l && !hit_r && !miss_l && (nx > X_HI);

    xb_n = nx[9:0];
    dx_n = dx;
    if (hit_l) begin
      xb_n = XB_HIT_L;
      dx_n = 1'b1;
    end else if (hit_r) begin
      xb_n = XB_HIT_R;
      dx_n = 1'b0;
    end else if (miss_l) begin
      xb_n = XB_MISS_L;
      dx_n = 1'b0;
    end else if (miss_r) begin
      xb_n = XB_MISS_R;
      dx_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SERVE;
      y1        <= PAD_Y_RST;
      y2        <= PAD_Y_RST;
      xb        <= BALL_X_CTR;
      yb        <= BALL_Y_CTR;
      dx        <= 1'b1;
      dy        <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
      serve_q   <= 1'b0;
      pause_cnt <= '0;
    end else if (frame_pulse) begin
      serve_q <= serve;
      if (state != S_OVER) begin
        y1 <= y1_next;
        y2 <= y2_next;
      end
      case (state)
        S_SERVE: begin
          xb <= BALL_X_CTR;
          yb <= BALL_Y_CTR;
          if (serve_edge) state <= S_PLAY;
        end
        S_PLAY: begin
          xb <= xb_n;
          yb <= yb_n;
          dx <= dx_n;
          dy <= dy_n;
          if (miss_l || miss_r) begin
            if (miss_l && score2 != SCORE_WIN) score2 <= score2 + 4'd1;
            if (miss_r && score1 != SCORE_WIN) score1 <= score1 + 4'd1;
            pause_cnt <= CW'(PAUSE_FRAMES - 1);
            state     <= S_POINT;
          end
        end
        S_POINT: begin
          if (pause_cnt == '0) begin
            if (score1 == SCORE_WIN || score2 == SCORE_WIN) begin
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              state <= S_SERVE;
              xb    <= BALL_X_CTR;
              yb    <= BALL_Y_CTR;
            end
          end else begin
            pause_cnt <= pause_cnt - 1'b1;
          end
        end
        S_OVER: begin
          if (serve_edge) begin
            score1    <= '0;
            score2    <= '0;
            xb        <= BALL_X_CTR;
            yb        <= BALL_Y_CTR;
            game_over <= 1'b0;
            state     <= S_SERVE;
          end
        end
        default: state <= S_SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: paddle vector table plus hand-traced ball trajectories,
// scoring, pause length, game-over and mid-pause reset.
module tb_pong_game_engine;
  logic clk = 1'b0;
  logic rst, frame_pulse, p1_up, p1_dn, p2_up, p2_dn, serve;
  logic [9:0] x1, y1, x2, y2, xb, yb;
  logic [3:0] score1, score2;
  logic game_over;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pong_game_engine dut (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .serve(serve),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .xb(xb), .yb(yb),
    .score1(score1), .score2(score2), .game_over(game_over)
  );

  typedef struct {
    logic u1, d1, u2, d2;
    int   ey1, ey2;
  } pad_vec_t;

  pad_vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    frame_pulse = 1'b1;
    @(negedge clk);
    frame_pulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_pulse = 1'b0;
    p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0; serve = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_ball(input string tag, input int ex, input int ey);
    chk({tag, "_xb"}, int'(xb), ex);
    chk({tag, "_yb"}, int'(yb), ey);
  endtask

  task automatic steer_p2();
    p2_up = (yb > 10'd240);
    p2_dn = !p2_up;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 0, 0, 200, 200};
    tbl[1] = '{1, 0, 0, 0, 196, 200};
    tbl[2] = '{1, 0, 0, 0, 192, 200};
    tbl[3] = '{0, 1, 0, 0, 196, 200};
    tbl[4] = '{1, 1, 0, 0, 196, 200};
    tbl[5] = '{0, 0, 1, 0, 196, 196};
    tbl[6] = '{0, 0, 0, 1, 196, 200};
    tbl[7] = '{0, 0, 1, 1, 196, 200};
    tbl[8] = '{0, 1, 0, 1, 200, 204};
    tbl[9] = '{0, 0, 1, 0, 200, 200};

    do_reset();
    chk("rst_y1", int'(y1), 200);
    chk("rst_y2", int'(y2), 200);
    chk("rst_x1", int'(x1), 16);
    chk("rst_x2", int'(x2), 614);
    chk_ball("rst", 320, 240);
    chk("rst_s1", int'(score1), 0);
    chk("rst_s2", int'(score2), 0);
    chk("rst_go", int'(game_over), 0);

    repeat (3) frame();
    chk("idle_y1", int'(y1), 200);
    chk("idle_y2", int'(y2), 200);
    chk_ball("idle", 320, 240);
    chk("idle_go", int'(game_over), 0);

    for (int i = 0; i < 10; i++) begin
      p1_up = tbl[i].u1; p1_dn = tbl[i].d1; p2_up = tbl[i].u2; p2_dn = tbl[i].d2;
      frame();
      chk("tbl_y1", int'(y1), tbl[i].ey1);
      chk("tbl_y2", int'(y2), tbl[i].ey2);
      chk_ball("tbl", 320, 240);
    end

    // buttons without a strobe must not move anything
    p1_up = 1; p2_dn = 1;
    repeat (6) @(negedge clk);
    chk("nostrobe_y1", int'(y1), 200);
    chk("nostrobe_y2", int'(y2), 200);

    p1_up = 1; p1_dn = 0; p2_up = 1; p2_dn = 1;
    for (int k = 1; k <= 60; k++) begin
      frame();
      chk("clamp_y1", int'(y1), (200 - 4 * k < 8) ? 8 : 200 - 4 * k);
      chk("both_y2", int'(y2), 200);
    end

    // Run A: right paddle bounce, left paddle bounce, right miss, then play to game over
    do_reset();
    p2_dn = 1; serve = 1;
    frame();
    chk_ball("serve_entry", 320, 240);
    for (int k = 1; k <= 740; k++) begin
      frame();
      case (k)
        1:   chk_ball("play1", 322, 242);
        145: chk_ball("pre_rhit", 610, 408);
        146: chk_ball("rhit", 610, 406);
        147: chk_ball("post_rhit", 608, 404);
        343: chk("top_exact", int'(yb), 12);
        344: chk("top_clamp", int'(yb), 12);
        345: chk("top_bounce", int'(yb), 14);
        437: chk_ball("lhit", 30, 198);
        438: chk_ball("post_lhit", 32, 200);
        739: chk_ball("pre_rmiss", 634, 136);
        740: begin
          chk_ball("rmiss", 635, 134);
          chk("rmiss_s1", int'(score1), 1);
          chk("rmiss_s2", int'(score2), 0);
        end
        default: ;
      endcase
    end
    for (int p = 1; p <= 60; p++) begin
      frame();
      if (p == 59) begin
        chk_ball("pause59", 635, 134);
        chk("pause59_s1", int'(score1), 1);
      end
      if (p == 60) chk_ball("pause60", 320, 240);
    end
    repeat (2) frame();
    chk_ball("held_serve", 320, 240);

    for (int r = 2; r <= 9; r++) begin
      serve = 0; frame();
      serve = 1; frame();
      for (int j = 1; j <= 158; j++) begin
        steer_p2();
        frame();
        if (j == 157) chk("round_pre_s1", int'(score1), r - 1);
      end
      chk("round_s1", int'(score1), r);
      chk_ball("round_miss", 635, (r % 2 == 0) ? 98 : 382);
      for (int p = 1; p <= 60; p++) begin
        steer_p2();
        frame();
        if (r < 9 && p == 60) chk_ball("round_recentre", 320, 240);
        if (r == 9 && p == 59) chk("go_pre", int'(game_over), 0);
        if (r == 9 && p == 60) chk("go_set", int'(game_over), 1);
      end
    end

    p2_up = 0; p2_dn = 0; p1_dn = 1;
    frame();
    chk("go_frozen_y1", int'(y1), 200);
    chk("go_frozen_xb", int'(xb), 635);
    chk("go_s1", int'(score1), 9);
    p1_dn = 0;
    serve = 0; frame();
    chk("go_hold", int'(game_over), 1);
    serve = 1; frame();
    chk("restart_s1", int'(score1), 0);
    chk("restart_s2", int'(score2), 0);
    chk_ball("restart", 320, 240);
    chk("restart_go", int'(game_over), 0);

    // Run B: left paddle out of position, left misses, then reset mid-pause
    do_reset();
    p1_up = 1; p2_dn = 1; serve = 1;
    frame();
    for (int k = 1; k <= 450; k++) begin
      frame();
      if (k == 437) chk("lpass_xb", int'(xb), 28);
      if (k == 449) chk("pre_lmiss_xb", int'(xb), 4);
      if (k == 450) begin
        chk_ball("lmiss", 4, 224);
        chk("lmiss_s2", int'(score2), 1);
        chk("lmiss_s1", int'(score1), 0);
      end
    end
    for (int p = 1; p <= 60; p++) begin
      frame();
      if (p == 60) chk_ball("lmiss_recentre", 320, 240);
    end
    serve = 0; frame();
    serve = 1; frame();
    for (int j = 1; j <= 159; j++) begin
      frame();
      if (j == 158) begin
        chk("lserve_pre_xb", int'(xb), 4);
        chk("lserve_pre_s2", int'(score2), 1);
      end
      if (j == 159) chk("lserve_s2", int'(score2), 2);
    end
    repeat (20) frame();
    @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_s2", int'(score2), 0);
    chk_ball("midrst", 320, 240);
    chk("midrst_y1", int'(y1), 200);
    chk("midrst_y2", int'(y2), 200);
    chk("midrst_go", int'(game_over), 0);
    @(negedge clk);
    rst = 0;
    p1_up = 0; p2_dn = 0; serve = 1;
    frame();
    chk_ball("after_rst_serve", 320, 240);
    frame();
    chk_ball("after_rst_play", 322, 242);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
